rgb_float_feeder: RTL
=====================

# rgb_float_feeder

Upstream feeder for the RGB-to-HSV datapath. Accepts 24-bit packed 8-bit RGB pixels through a valid/ready handshake and buffers them in a small FIFO. Converts each channel exactly to IEEE-754 single precision and presents one 96-bit {R,G,B} word per transfer to the HSV controller/datapath input. Holds each word stable until the consumer accepts it.

## Interface
- FIFO_DEPTH, 4: pixel FIFO entries; power of two, >= 2.
- LVL_W, $clog2(FIFO_DEPTH)+1: width of `fifo_level`.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_data  in  24  R in [23:16], G in [15:8], B in [7:0]; unsigned 0..255.
- pix_valid  in  1  upstream presents `pix_data`.
- pix_ready  out  1  FIFO can accept; a transfer occurs when `pix_valid` && `pix_ready` at the edge.
- out_data  out  96  {R_f32, G_f32, B_f32}: R in [95:64], G in [63:32], B in [31:0].
- out_valid  out  1  `out_data` holds a converted pixel.
- out_ready  in  1  consumer accepts; a transfer occurs when `out_valid` && `out_ready` at the edge.
- fifo_level  out  LVL_W  entries currently in the FIFO (0..FIFO_DEPTH).
- pix_count  out  16  number of completed output transfers; wraps 0xFFFF -> 0x0000.

## Operation
- FIFO: circular buffer with read/write pointers and a registered level count.
  - `pix_ready` = (fifo_level != FIFO_DEPTH). It is derived from the registered level only, never from the same-cycle pop.
  - Push on an input transfer.
  - Pop when the FIFO is non-empty and the output register is loadable.
  - Level update: push only +1; pop only -1; push and pop together leaves it unchanged.
- Output register loadability: loadable when `out_valid`==0, or when `out_valid`==1 and `out_ready`==1 (an accept this edge).
- On a loadable edge:
  - FIFO non-empty: pop the head, load its converted value into `out_data`, set `out_valid`=1.
  - FIFO empty and accept this edge: clear `out_valid`; `out_data` keeps its last value.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold unchanged.
- Channel conversion (combinational on the FIFO head, per channel c):
  - c==0 -> 0x00000000.
  - Otherwise let p be the MSB position (0..7):
    - sign = 0;
    - exponent = 127+p;
    - mantissa[22:0] = (c << (23-p)) with the hidden bit dropped.
  - The result is exact; no rounding occurs.
- `pix_count` increments by 1 on every output transfer, modulo 2^16.

## Timing
- Reset (asynchronous on `rst_n` low, held while low):
  - `out_valid`=0, `out_data`=0, `fifo_level`=0;
  - pointers = 0, `pix_count`=0;
  - `pix_ready`=1 once reset is released (it is 1 during reset as the level is 0).
  - FIFO contents are undefined and never observed.
- Reset mid-operation: all buffered pixels and any pending output are discarded. No transfer completes in the reset cycle.
- Latency with an empty FIFO and idle output: input transfer at edge k -> `out_valid`=1 with the converted data after edge k+1.
- Sustained throughput: 1 pixel/cycle when `out_ready` is held high.
- Full FIFO: `pix_ready`=0. A pop at full raises `pix_ready` in the following cycle, not the same cycle.
- Empty FIFO with `out_ready` high: `out_valid` drops after the accepting edge. No duplicate word is ever issued.
- Pointer wrap at FIFO_DEPTH-1 -> 0 must preserve ordering across the wrap.

## Test plan
1. Reset then single pixel 0xFF0180 -> `out_data` = {0x437F0000, 0x3F800000, 0x43000000} one cycle after acceptance. `pix_count` goes 0 -> 1 on accept.
2. Pixel 0x000000 -> `out_data` = 0; pixel 0x070203 -> {0x40E00000, 0x40000000, 0x40400000}.
3. `out_ready`=0 while 6 pixels are offered with FIFO_DEPTH=4:
   - 5 accepted (4 in the FIFO, 1 in the output register);
   - `pix_ready`=0, `fifo_level`=4;
   - `out_data` stable.
   - Release `out_ready` -> all 6 appear in order, no loss or duplication.
4. `out_ready`=1 and a continuous stream of 10 pixels 0x010101..0x0A0A0A -> one output per cycle, in order; pointers wrap twice; `fifo_level` stays <= 1.
5. Assert `rst_n` low mid-stream with `fifo_level`=3 and `out_valid`=1 -> outputs go to the reset values immediately. After release, the next pixel is the first output.
6. Preload `pix_count`=0xFFFF via 65535 transfers (or force), then one more transfer -> `pix_count`=0x0000.

Source files
------------

// File: rtl/rgb_float_feeder.sv
// Pixel FIFO in front of the RGB-to-HSV datapath: buffers 8-bit RGB pixels and
// presents each one as three exact IEEE-754 single-precision channels.
module rgb_float_feeder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [23:0]      pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [95:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic [15:0]      pix_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [23:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             push;
    logic             pop;
    logic             loadable;
    logic             accept;
    logic [23:0]      head;
    logic [95:0]      head_f32;

    // An 8-bit integer always fits the 24-bit significand, so the conversion is exact.
    function automatic logic [31:0] to_f32(input logic [7:0] c);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                r = {1'b0, 8'(127 + i), 23'({15'b0, c} << (23 - i))};
            end
        end
        return r;
    endfunction

    always_comb begin
        pix_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
        push      = pix_valid && pix_ready;
        accept    = out_valid && out_ready;
        loadable  = !out_valid || out_ready;
        pop       = (fifo_level != '0) && loadable;
        head      = mem[rd_ptr_q];
        head_f32  = {to_f32(head[23:16]), to_f32(head[15:8]), to_f32(head[7:0])};
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            pix_count <= '0;
        end else begin
            if (pop) begin
                out_data  <= head_f32;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                pix_count <= pix_count + 1'b1;
            end
        end
    end

endmodule
